pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register for the 5-stage MIPS core, replacing the per-stage hand-written registers (D/E/M/W) with one generic block. Carries instruction, PC, N data fields and M flag bits between stages with a valid/ready handshake and a 2-entry skid buffer, so no combinational path crosses the stage boundary. Supports exception flush (PC forced to the handler vector) and a saturating stall-cycle counter for performance debug.

## Interface
- NUM_FIELDS, 7, number of DATA_W-bit payload fields (ALU, DM, EXT, rs, rt, MDU, CP0 for W stage)
- DATA_W, 32, width of instr, PC and each payload field
- NUM_FLAGS, 3, number of 1-bit flags
- RESET_PC, 32'h0000_3000, out_pc after reset
- HANDLER_PC, 32'h0000_4180, out_pc after req
- CNT_W, 16, stall counter width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req  in  1  exception/interrupt flush, sampled on clk
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; registered
- in_instr  in  DATA_W  instruction word
- in_pc  in  DATA_W  instruction PC
- in_data  in  NUM_FIELDS*DATA_W  packed payload, field 0 in LSBs
- in_flags  in  NUM_FLAGS  flag bits
- out_valid  out  1  downstream entry valid
- out_ready  in  1  downstream accepts
- out_instr, out_pc, out_data, out_flags  out  as inputs  current entry
- stall_cycles  out  CNT_W  count of back-pressured cycles

## Operation
- State: main entry (drives outputs) + skid entry, each with valid bit.
- Accept = in_valid && in_ready. in_ready = !skid_valid.
- Main advances when !main_valid || out_ready: loads skid if skid_valid (skid cleared), else loads input if accepted, else becomes empty.
- Accept while main held (main_valid && !out_ready): entry written to skid.
- Main becomes empty: out_instr, out_data, out_flags load 0 (bubble = nop); out_pc holds last value.
- req (synchronous): both valids cleared, instr/data/flags zeroed, out_pc = HANDLER_PC; any entry accepted that cycle is discarded. req has priority over all handshake activity.
- reset (asynchronous): as req but out_pc = RESET_PC, stall_cycles = 0.
- stall_cycles increments when out_valid && !out_ready; saturates at all-ones; cleared only by reset, not by req.
- Ordering strictly FIFO; no entry duplicated or dropped except by req/reset.

## Timing
- Reset values: out_valid 0, in_ready 1, out_instr 0, out_pc RESET_PC, out_data 0, out_flags 0, stall_cycles 0.
- Latency: accepted input visible on outputs next cycle when main empty or draining.
- Throughput: 1 entry/cycle with out_ready held high.
- in_ready depends only on registered skid_valid; falls the cycle after a skid write, rises the cycle after skid drains.
- Skid full + out_ready low: in_ready 0, state frozen, counter increments.
- Skid full + out_ready high: main <- skid, input not accepted that cycle (in_ready was 0).
- req same cycle as out_ready: downstream transfer of current out entry counts as completed; stage empty next cycle.
- reset asserted mid-transfer: outputs reset immediately, independent of clk.

## Structure
- Shared package core_pkg: RESET_PC and HANDLER_PC constants (reused by PC unit and CP0), DATA_W default.
- One natural sub-module: stage_entry (valid + payload register with load/clear), instantiated twice (main, skid).

## Test plan
- Reset: assert reset between edges -> out_pc 0x3000, out_valid 0, in_ready 1 immediately.
- Stream: 4 entries, pc 0x3000..0x300c, out_ready=1 -> same order out, 1-cycle latency, no bubbles.
- Back-pressure: out_ready=0 for 5 cycles while sending 3 entries -> 2 held (main+skid), in_ready 0 from cycle 2, third accepted after release, stall_cycles = 5, order preserved.
- Flush: req during full skid with pc 0x3010/0x3014 -> next cycle out_valid 0, in_ready 1, out_pc 0x4180, out_instr 0; stall_cycles unchanged.
- Bubble: single entry pc 0x3020 drained, no new input -> out_instr 0, out_pc stays 0x3020.
- Saturation: CNT_W=4, 20 stalled cycles -> stall_cycles = 15.

Source files
------------

// File: rtl/core_pkg.sv
// Constants shared across the MIPS core. The PC unit, CP0 and the stage
// registers all need to agree on the reset and exception handler addresses.
package core_pkg;

  localparam int          DATA_W     = 32;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

endpackage

// File: rtl/stage_entry.sv
// One pipeline entry: valid bit plus instr/pc/payload/flags.
// Clear zeroes instr, data and flags and drops valid, which makes the entry a
// nop bubble. The PC normally holds across a clear so that debug views keep the
// last address. force_pc overrides it, which is how a flush redirects the PC.
module stage_entry #(
  parameter int                NUM_FIELDS = 7,
  parameter int                DATA_W     = 32,
  parameter int                NUM_FLAGS  = 3,
  parameter logic [DATA_W-1:0] RESET_PC   = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic                         clear,
  input  logic                         force_pc,
  input  logic [DATA_W-1:0]            force_pc_value,
  input  logic [DATA_W-1:0]            d_instr,
  input  logic [DATA_W-1:0]            d_pc,
  input  logic [NUM_FIELDS*DATA_W-1:0] d_data,
  input  logic [NUM_FLAGS-1:0]         d_flags,
  output logic                         valid,
  output logic [DATA_W-1:0]            instr,
  output logic [DATA_W-1:0]            pc,
  output logic [NUM_FIELDS*DATA_W-1:0] data,
  output logic [NUM_FLAGS-1:0]         flags
);

  // Entry register. Clear has priority over load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= RESET_PC;
      data  <= '0;
      flags <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      instr <= '0;
      data  <= '0;
      flags <= '0;
      if (force_pc) pc <= force_pc_value;
    end else if (load) begin
      valid <= 1'b1;
      instr <= d_instr;
      pc    <= d_pc;
      data  <= d_data;
      flags <= d_flags;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with a valid/ready handshake and a 2-entry
// skid buffer. The main entry drives the outputs directly and the skid entry
// catches the one word that can arrive while main is held. in_ready comes
// straight from the skid valid flop, so no combinational path runs from
// out_ready back to in_ready.
module pipe_stage_reg #(
  parameter int                NUM_FIELDS = 7,
  parameter int                DATA_W     = core_pkg::DATA_W,
  parameter int                NUM_FLAGS  = 3,
  parameter logic [DATA_W-1:0] RESET_PC   = DATA_W'(core_pkg::RESET_PC),
  parameter logic [DATA_W-1:0] HANDLER_PC = DATA_W'(core_pkg::HANDLER_PC),
  parameter int                CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_instr,
  input  logic [DATA_W-1:0]            in_pc,
  input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
  input  logic [NUM_FLAGS-1:0]         in_flags,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_instr,
  output logic [DATA_W-1:0]            out_pc,
  output logic [NUM_FIELDS*DATA_W-1:0] out_data,
  output logic [NUM_FLAGS-1:0]         out_flags,
  output logic [CNT_W-1:0]             stall_cycles
);

  logic                         main_valid;
  logic                         skid_valid;
  logic [DATA_W-1:0]            skid_instr;
  logic [DATA_W-1:0]            skid_pc;
  logic [NUM_FIELDS*DATA_W-1:0] skid_data;
  logic [NUM_FLAGS-1:0]         skid_flags;

  logic                         advance;
  logic                         accept;
  logic                         main_load;
  logic                         main_clear;
  logic                         skid_load;
  logic                         skid_clear;
  logic [DATA_W-1:0]            main_d_instr;
  logic [DATA_W-1:0]            main_d_pc;
  logic [NUM_FIELDS*DATA_W-1:0] main_d_data;
  logic [NUM_FLAGS-1:0]         main_d_flags;

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;

  // Handshake decode. A flush (req) overrides every load and empties both
  // entries. Any word accepted in the same cycle is discarded with them.
  always_comb begin
    advance    = !main_valid || out_ready;
    accept     = in_valid && !skid_valid;
    main_load  = !req && advance && (skid_valid || accept);
    main_clear = req || (advance && !skid_valid && !accept);
    skid_load  = !req && accept && !advance;
    skid_clear = req || (skid_valid && advance);
    if (skid_valid) begin
      main_d_instr = skid_instr;
      main_d_pc    = skid_pc;
      main_d_data  = skid_data;
      main_d_flags = skid_flags;
    end else begin
      main_d_instr = in_instr;
      main_d_pc    = in_pc;
      main_d_data  = in_data;
      main_d_flags = in_flags;
    end
  end

  stage_entry #(
    .NUM_FIELDS(NUM_FIELDS), .DATA_W(DATA_W), .NUM_FLAGS(NUM_FLAGS), .RESET_PC(RESET_PC)
  ) u_main (
    .clk            (clk),
    .rst            (reset),
    .load           (main_load),
    .clear          (main_clear),
    .force_pc       (req),
    .force_pc_value (HANDLER_PC),
    .d_instr        (main_d_instr),
    .d_pc           (main_d_pc),
    .d_data         (main_d_data),
    .d_flags        (main_d_flags),
    .valid          (main_valid),
    .instr          (out_instr),
    .pc             (out_pc),
    .data           (out_data),
    .flags          (out_flags)
  );

  stage_entry #(
    .NUM_FIELDS(NUM_FIELDS), .DATA_W(DATA_W), .NUM_FLAGS(NUM_FLAGS), .RESET_PC(RESET_PC)
  ) u_skid (
    .clk            (clk),
    .rst            (reset),
    .load           (skid_load),
    .clear          (skid_clear),
    .force_pc       (1'b0),
    .force_pc_value (HANDLER_PC),
    .d_instr        (in_instr),
    .d_pc           (in_pc),
    .d_data         (in_data),
    .d_flags        (in_flags),
    .valid          (skid_valid),
    .instr          (skid_instr),
    .pc             (skid_pc),
    .data           (skid_data),
    .flags          (skid_flags)
  );

  // Saturating back-pressure counter. A flush deliberately leaves it alone so
  // that stall statistics survive exceptions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (main_valid && !out_ready && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed table of the handshake scenarios, a
// counter saturation sequence, an asynchronous reset check, then randomized
// traffic compared against a queue-based model of the stage.
module tb_pipe_stage_reg;

  localparam int NF  = 7;
  localparam int DW  = 32;
  localparam int NFL = 3;
  localparam int CW  = 4;
  localparam logic [31:0] RPC = 32'h0000_3000;
  localparam logic [31:0] HPC = 32'h0000_4180;

  logic              clk = 1'b0;
  logic              reset;
  logic              req;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_instr;
  logic [DW-1:0]     in_pc;
  logic [NF*DW-1:0]  in_data;
  logic [NFL-1:0]    in_flags;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_instr;
  logic [DW-1:0]     out_pc;
  logic [NF*DW-1:0]  out_data;
  logic [NFL-1:0]    out_flags;
  logic [CW-1:0]     stall_cycles;

  int n_chk = 0;
  int n_err = 0;

  pipe_stage_reg #(
    .NUM_FIELDS(NF), .DATA_W(DW), .NUM_FLAGS(NFL), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .req(req),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_data(in_data), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_data(out_data), .out_flags(out_flags),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]    instr;
    logic [DW-1:0]    pc;
    logic [NF*DW-1:0] data;
    logic [NFL-1:0]   flags;
  } ent_t;

  typedef struct {
    bit          rq, iv, ordy;
    logic [31:0] pc;
    bit          e_ov, e_ir;
    logic [31:0] e_pc;
    int          e_st;
  } vec_t;

  // Behavioural model: stage contents as a FIFO of at most two entries.
  ent_t        mq[$];
  logic [31:0] m_pc;
  int          m_stall;

  function automatic ent_t mk_ent(logic [31:0] pc);
    ent_t e;
    e.instr = {16'hC0DE, pc[15:0]};
    e.pc    = pc;
    e.data  = {NF{pc ^ 32'h5A5A_0000}};
    e.flags = pc[4:2];
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    e.instr = $urandom;
    e.pc    = $urandom;
    for (int k = 0; k < NF; k++) e.data[k*DW +: DW] = $urandom;
    e.flags = NFL'($urandom);
    return e;
  endfunction

  function automatic vec_t mkv(bit rq, bit iv, bit ordy, logic [31:0] pc,
                               bit e_ov, bit e_ir, logic [31:0] e_pc, int e_st);
    vec_t v;
    v.rq = rq; v.iv = iv; v.ordy = ordy; v.pc = pc;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_pc = e_pc; v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc    = RPC;
    m_stall = 0;
  endtask

  task automatic model_step(bit rq, bit iv, bit ordy, ent_t e);
    bit acc;
    if (mq.size() > 0 && !ordy && m_stall < (2**CW - 1)) m_stall++;
    if (rq) begin
      mq.delete();
      m_pc = HPC;
    end else begin
      acc = iv && (mq.size() < 2);
      if (mq.size() > 0 && ordy) void'(mq.pop_front());
      if (acc) mq.push_back(e);
      if (mq.size() > 0) m_pc = mq[0].pc;
    end
  endtask

  task automatic check_model(string tag);
    bit ov;
    ov = mq.size() > 0;
    chk({tag, ".out_valid"}, 256'(out_valid), 256'(ov));
    chk({tag, ".in_ready"},  256'(in_ready),  256'(mq.size() < 2));
    chk({tag, ".out_pc"},    256'(out_pc),    256'(m_pc));
    chk({tag, ".out_instr"}, 256'(out_instr), ov ? 256'(mq[0].instr) : 256'(0));
    chk({tag, ".out_data"},  256'(out_data),  ov ? 256'(mq[0].data)  : 256'(0));
    chk({tag, ".out_flags"}, 256'(out_flags), ov ? 256'(mq[0].flags) : 256'(0));
    chk({tag, ".stall"},     256'(stall_cycles), 256'(m_stall));
  endtask

  // Apply one cycle of stimulus, advance the model across the edge.
  task automatic drive(bit rq, bit iv, bit ordy, ent_t e);
    req = rq; in_valid = iv; out_ready = ordy;
    in_instr = e.instr; in_pc = e.pc; in_data = e.data; in_flags = e.flags;
    @(posedge clk);
    model_step(rq, iv, ordy, e);
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must react before any edge.
  task automatic async_reset(string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk({tag, ".rst_out_valid"}, 256'(out_valid), 256'(0));
    chk({tag, ".rst_in_ready"},  256'(in_ready),  256'(1));
    chk({tag, ".rst_out_pc"},    256'(out_pc),    256'(RPC));
    chk({tag, ".rst_out_instr"}, 256'(out_instr), 256'(0));
    chk({tag, ".rst_stall"},     256'(stall_cycles), 256'(0));
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[21];

  initial begin
    ent_t e;
    logic [31:0] xp;
    tbl[0]  = mkv(0, 1, 1, 32'h3000, 1, 1, 32'h3000, 0);
    tbl[1]  = mkv(0, 1, 1, 32'h3004, 1, 1, 32'h3004, 0);
    tbl[2]  = mkv(0, 1, 1, 32'h3008, 1, 1, 32'h3008, 0);
    tbl[3]  = mkv(0, 1, 1, 32'h300c, 1, 1, 32'h300c, 0);
    tbl[4]  = mkv(0, 0, 1, 32'h0,    0, 1, 32'h300c, 0);
    tbl[5]  = mkv(0, 1, 1, 32'h3010, 1, 1, 32'h3010, 0);
    tbl[6]  = mkv(0, 1, 0, 32'h3014, 1, 0, 32'h3010, 1);
    tbl[7]  = mkv(0, 1, 0, 32'h3018, 1, 0, 32'h3010, 2);
    tbl[8]  = mkv(0, 1, 0, 32'h3018, 1, 0, 32'h3010, 3);
    tbl[9]  = mkv(0, 1, 0, 32'h3018, 1, 0, 32'h3010, 4);
    tbl[10] = mkv(0, 1, 0, 32'h3018, 1, 0, 32'h3010, 5);
    tbl[11] = mkv(0, 1, 1, 32'h3018, 1, 1, 32'h3014, 5);
    tbl[12] = mkv(0, 1, 1, 32'h3018, 1, 1, 32'h3018, 5);
    tbl[13] = mkv(0, 0, 1, 32'h0,    0, 1, 32'h3018, 5);
    tbl[14] = mkv(0, 1, 0, 32'h3010, 1, 1, 32'h3010, 5);
    tbl[15] = mkv(0, 1, 0, 32'h3014, 1, 0, 32'h3010, 6);
    tbl[16] = mkv(1, 0, 1, 32'h0,    0, 1, 32'h4180, 6);
    tbl[17] = mkv(1, 1, 1, 32'h3030, 0, 1, 32'h4180, 6);
    tbl[18] = mkv(0, 1, 1, 32'h3020, 1, 1, 32'h3020, 6);
    tbl[19] = mkv(0, 0, 1, 32'h0,    0, 1, 32'h3020, 6);
    tbl[20] = mkv(0, 0, 0, 32'h0,    0, 1, 32'h3020, 6);

    reset = 1'b1; req = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_data = '0; in_flags = '0;
    model_reset();
    #1;
    chk("init.out_pc",    256'(out_pc),    256'(RPC));
    chk("init.out_valid", 256'(out_valid), 256'(0));
    chk("init.in_ready",  256'(in_ready),  256'(1));
    #11;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed table: stream, back-pressure, flush, bubble.
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].rq, tbl[i].iv, tbl[i].ordy, mk_ent(tbl[i].pc));
      xp = tbl[i].e_pc;
      e  = mk_ent(xp);
      chk($sformatf("vec%0d.out_valid", i), 256'(out_valid), 256'(tbl[i].e_ov));
      chk($sformatf("vec%0d.in_ready", i),  256'(in_ready),  256'(tbl[i].e_ir));
      chk($sformatf("vec%0d.out_pc", i),    256'(out_pc),    256'(xp));
      chk($sformatf("vec%0d.out_instr", i), 256'(out_instr), tbl[i].e_ov ? 256'(e.instr) : 256'(0));
      chk($sformatf("vec%0d.out_data", i),  256'(out_data),  tbl[i].e_ov ? 256'(e.data)  : 256'(0));
      chk($sformatf("vec%0d.out_flags", i), 256'(out_flags), tbl[i].e_ov ? 256'(e.flags) : 256'(0));
      chk($sformatf("vec%0d.stall", i),     256'(stall_cycles), 256'(tbl[i].e_st));
    end

    // Counter saturation: one held entry, 20 stalled cycles, 4-bit counter.
    async_reset("sat_pre");
    drive(0, 1, 0, mk_ent(32'h3040));
    for (int i = 0; i < 20; i++) drive(0, 0, 0, mk_ent(32'h0));
    chk("sat.stall",     256'(stall_cycles), 256'(15));
    chk("sat.out_valid", 256'(out_valid),    256'(1));
    chk("sat.out_pc",    256'(out_pc),       256'(32'h3040));
    async_reset("sat_post");

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) async_reset("rnd_mid");
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, rnd_ent());
      check_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
